// File: rtl/fifo_burst_reader.sv
// FIFO burst reader: pops bursts of i_burst_len beats, or drains a nearly-empty FIFO after an idle timeout.
// Optional burst statistics counter enabled by macro FIFO_BURST_READER_STATS_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; timeout counter runs while FIFO is almost empty
// S_BURST | popping up to r_target beats, last beat flagged
// S_DRAIN | popping single-beat bursts until the FIFO runs dry
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 8,
   parameter int TO_WIDTH   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_valid,
   input  logic                  i_fifo_almostempty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_ready,
   input  logic [WIDTH-1:0]      i_burst_len,
   input  logic [TO_WIDTH-1:0]   i_timeout,
   input  logic                  i_ready_d,
   output logic                  o_valid_d,
   output logic [DATA_WIDTH-1:0] o_data_d,
   output logic                  o_last_d,
   output logic                  o_busy,
   output logic [15:0]           o_burst_total
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_target;
   logic [WIDTH-1:0]    r_beats;
   logic [TO_WIDTH-1:0] r_to_cnt;

   logic w_room;
   logic w_pop;
   logic w_last_acc;
   logic w_beat_last;

   assign w_room      = !o_valid_d || i_ready_d;
   assign w_pop       = o_fifo_ready && i_fifo_valid;
   assign w_last_acc  = o_valid_d && o_last_d && i_ready_d;
   assign w_beat_last = (WIDTH'(r_beats + WIDTH'(1)) == r_target);
   assign o_busy      = (r_state != S_IDLE);

   always_comb begin
      o_fifo_ready = 1'b0;
      if (!i_rst) begin
         case (r_state)
            S_BURST: o_fifo_ready = (r_beats < r_target) && w_room;
            S_DRAIN: o_fifo_ready = w_room;
            default: o_fifo_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_target  <= '0;
         r_beats   <= '0;
         r_to_cnt  <= '0;
         o_valid_d <= 1'b0;
         o_last_d  <= 1'b0;
         o_data_d  <= '0;
      end else begin
         // output register: reload on pop, otherwise empty it once accepted
         if (w_pop) begin
            o_data_d  <= i_fifo_data;
            o_valid_d <= 1'b1;
            o_last_d  <= (r_state == S_DRAIN) || w_beat_last;
         end else if (i_ready_d) begin
            o_valid_d <= 1'b0;
            o_last_d  <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_beats <= '0;
               if (i_fifo_valid && !i_fifo_almostempty) begin
                  r_state  <= S_BURST;
                  r_target <= (i_burst_len == '0) ? WIDTH'(1) : i_burst_len;
                  r_to_cnt <= '0;
               end else if ((i_timeout != '0) && (r_to_cnt == i_timeout) && i_fifo_valid) begin
                  r_state  <= S_DRAIN;
                  r_to_cnt <= '0;
               end else if (i_fifo_valid && i_fifo_almostempty) begin
                  if (r_to_cnt != '1)
                     r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
               end else begin
                  r_to_cnt <= '0;
               end
            end
            S_BURST: begin
               if (w_pop)
                  r_beats <= r_beats + WIDTH'(1);
               if (w_last_acc)
                  r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (w_room && !i_fifo_valid)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FIFO_BURST_READER_STATS_EN
   logic [15:0] r_burst_total;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_burst_total <= '0;
      else if (w_last_acc)
         r_burst_total <= r_burst_total + 16'd1;
   end

   assign o_burst_total = r_burst_total;
`else
   assign o_burst_total = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-backed FIFO model and beat collector.
// Expected o_burst_total follows FIFO_BURST_READER_STATS_EN.
module tb_fifo_burst_reader;
   localparam int DW = 32;
   localparam int BW = 8;
   localparam int TW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_fifo_valid = 1'b0;
   logic          i_fifo_almostempty = 1'b0;
   logic [DW-1:0] i_fifo_data = '0;
   logic          o_fifo_ready;
   logic [BW-1:0] i_burst_len = 8'd4;
   logic [TW-1:0] i_timeout = '0;
   logic          i_ready_d = 1'b1;
   logic          o_valid_d;
   logic [DW-1:0] o_data_d;
   logic          o_last_d;
   logic          o_busy;
   logic [15:0]   o_burst_total;

   fifo_burst_reader #(.DATA_WIDTH(DW), .WIDTH(BW), .TO_WIDTH(TW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_fifo_valid(i_fifo_valid), .i_fifo_almostempty(i_fifo_almostempty),
      .i_fifo_data(i_fifo_data), .o_fifo_ready(o_fifo_ready),
      .i_burst_len(i_burst_len), .i_timeout(i_timeout),
      .i_ready_d(i_ready_d), .o_valid_d(o_valid_d), .o_data_d(o_data_d),
      .o_last_d(o_last_d), .o_busy(o_busy), .o_burst_total(o_burst_total)
   );

   always #5 i_clk = ~i_clk;

   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            ae_level = 2;
   logic [DW-1:0] q[$];
   logic [DW-1:0] acc_d[$];
   logic          acc_l[$];
   int            acc_t[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // one clock: drive FIFO view, sample pop/acceptance before the edge, settle after it
   task automatic tick();
      logic pop;
      i_fifo_valid       = (q.size() != 0);
      i_fifo_data        = (q.size() != 0) ? q[0] : '0;
      i_fifo_almostempty = (q.size() <= ae_level);
      #1;
      pop = o_fifo_ready & i_fifo_valid;
      if (o_valid_d && i_ready_d && !i_rst) begin
         acc_d.push_back(o_data_d);
         acc_l.push_back(o_last_d);
         acc_t.push_back(cyc);
      end
      @(posedge i_clk);
      #1;
      cyc++;
      if (pop) void'(q.pop_front());
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int b;
      b = budget;
      while (acc_d.size() < n && b > 0) begin
         tick();
         b--;
      end
      chk(tag, acc_d.size(), n);
   endtask

   task automatic load(input logic [DW-1:0] base, input int n);
      q.delete();
      acc_d.delete();
      acc_l.delete();
      acc_t.delete();
      for (int i = 0; i < n; i++) q.push_back(base + DW'(i));
   endtask

   function automatic logic [3:0] last4();
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < 4 && i < acc_l.size(); i++) v[i] = acc_l[i];
      return v;
   endfunction

   initial begin
      logic [15:0] exp_total;
`ifdef FIFO_BURST_READER_STATS_EN
      exp_total = 16'd3;
`else
      exp_total = 16'd0;
`endif
      repeat (3) tick();
      chk("rst_valid", o_valid_d, 0);
      chk("rst_last", o_last_d, 0);
      chk("rst_data", o_data_d, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_fifo_ready, 0);
      chk("rst_total", o_burst_total, 0);
      i_rst = 1'b0;

      // full burst of 4 from a 6-word FIFO, then idle with timeout disabled
      load(32'hA000_0000, 6);
      run_until("b4_cnt", 4, 20);
      for (int i = 0; i < 4; i++) chk("b4_data", acc_d[i], 32'hA000_0000 + i);
      chk("b4_last", last4(), 4'b1000);
      chk("b4_consec", acc_t[3] - acc_t[0], 3);
      chk("b4_idle", o_busy, 0);
      repeat (30) tick();
      chk("to0_nobeat", acc_d.size(), 4);
      chk("to0_idle", o_busy, 0);
      chk("to0_qsize", q.size(), 2);

      // downstream stall on beat 2
      load(32'hB000_0000, 6);
      run_until("st_pre", 1, 20);
      i_ready_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_valid", o_valid_d, 1);
         chk("st_data", o_data_d, 32'hB000_0001);
         chk("st_last", o_last_d, 0);
         chk("st_nopop", q.size(), 4);
      end
      i_ready_d = 1'b1;
      run_until("st_cnt", 4, 20);
      for (int i = 0; i < 4; i++) chk("st_order", acc_d[i], 32'hB000_0000 + i);
      chk("st_lastpat", last4(), 4'b1000);

      // timeout drain of 2 words
      q.delete();
      tick();
      i_timeout = 16'd10;
      load(32'hC000_0000, 2);
      repeat (10) tick();
      chk("dr_wait", o_busy, 0);
      tick();
      chk("dr_enter", o_busy, 1);
      run_until("dr_cnt", 2, 10);
      chk("dr_d0", acc_d[0], 32'hC000_0000);
      chk("dr_d1", acc_d[1], 32'hC000_0001);
      chk("dr_last", {acc_l[1], acc_l[0]}, 2'b11);
      chk("dr_idle", o_busy, 0);

      // burst_len 0 behaves as single-beat bursts
      i_timeout   = '0;
      ae_level    = 0;
      i_burst_len = 8'd0;
      load(32'hD000_0000, 4);
      run_until("bl0_cnt", 4, 30);
      for (int i = 0; i < 4; i++) chk("bl0_data", acc_d[i], 32'hD000_0000 + i);
      chk("bl0_last", last4(), 4'b1111);

      // reset in the middle of a 4-beat burst
      i_burst_len = 8'd4;
      load(32'hE000_0000, 6);
      run_until("mr_pre", 1, 20);
      i_rst = 1'b1;
      tick();
      chk("mr_valid", o_valid_d, 0);
      chk("mr_last", o_last_d, 0);
      chk("mr_data", o_data_d, 0);
      chk("mr_busy", o_busy, 0);
      chk("mr_ready", o_fifo_ready, 0);
      chk("mr_nopop", q.size(), 4);
      i_rst = 1'b0;

      // three complete bursts after reset
      load(32'hF000_0000, 12);
      run_until("st3_cnt", 12, 80);
      chk("st3_lasts", {acc_l[11], acc_l[7], acc_l[3]}, 3'b111);
      chk("st3_total", o_burst_total, exp_total);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
